// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: base opcodes and the immediate format code
// used by the ID-stage immediate decoder.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
// Ports:
//   instr   - raw 32-bit instruction word
//   imm     - XLEN-wide sign/zero-extended immediate (0 for R-format/illegal)
//   fmt     - immediate format classification
//   illegal - opcode not recognised
module imm_extract
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic       is_shift;

    assign opcode   = instr[6:0];
    // funct3 001 (sll) and 101 (srl/sra) carry a shift amount, not an immediate
    assign is_shift = (instr[13:12] == 2'b01);

    always_comb begin
        imm     = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                if (is_shift)
                    imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                else
                    imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OPIMM32: begin
                fmt = FMT_I;
                if (is_shift)
                    imm = XLEN'(instr[24:20]);
                else
                    imm = XLEN'($signed(instr[31:20]));
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OPC_OP, OPC_OP32: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes the immediate and format of the
// incoming instruction, computes pc + imm, and holds the result in a two-slot
// skid buffer (main drives the outputs, skid absorbs one extra entry) so both
// sides can stall independently at full throughput.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   flush             - synchronous kill of all buffered entries
//   in_valid/in_ready - upstream handshake; in_ready is !skid occupancy
//   in_instr, in_pc   - instruction word and its pc
//   out_valid/out_ready - downstream handshake
//   out_imm, out_fmt, out_target, out_pc, out_illegal - decoded entry
module imm_decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } slot_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    slot_t           dec;

    slot_t main_q;
    slot_t skid_q;
    logic  main_valid;
    logic  skid_valid;
    logic  push;
    logic  pop;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    always_comb begin
        dec.imm     = dec_imm;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
        dec.pc      = in_pc;
        dec.target  = in_pc + dec_imm;
    end

    assign in_ready = !skid_valid;
    assign push     = in_valid && in_ready;
    assign pop      = main_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            // flush also swallows a same-cycle push
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            // skid full implies in_ready=0, so no push can coincide here
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (push) begin
                main_q <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (push) begin
            if (!main_valid) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;
    assign out_target  = main_q.target;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised, registered immediate-decode stage for the RISC-V pipeline's ID stage. It decodes the immediate for every base format (I, S, B, U, J, plus R/shift cases) to an XLEN-wide sign-extended value and classifies the format. It also computes the PC-relative target (pc + imm). All of this sits behind a two-entry skid buffer with valid/ready handshake and flush, so upstream fetch and downstream execute can stall independently at full throughput.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all buffered entries (branch mispredict/trap).
- in_valid  input  1  instruction/pc pair is presented.
- in_ready  output  1  stage can accept; registered, depends only on skid occupancy.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  decoded entry is presented.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  sign/zero-extended immediate.
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
- out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_pc  output  XLEN  forwarded pc.
- out_illegal  output  1  opcode not recognised; imm=0, fmt=R.

## Operation
- Decode is on opcode = instr[6:0], not on partial bits:
  - I-format (imm = sext(instr[31:20])):
    - 0000011 load
    - 0010011 op-imm
    - 0011011 op-imm-32
    - 1100111 jalr
    - 1110011 system
  - Shift exception:
    - op-imm with funct3 001/101: imm = zext(instr[25:20]) if XLEN=64, else zext(instr[24:20]).
    - op-imm-32 with funct3 001/101: imm = zext(instr[24:20]).
  - S-format, 0100011: sext({instr[31:25], instr[11:7]}).
  - B-format, 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); bit 0 is always 0.
  - U-format, 0110111/0010111: sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate instr[31].
  - J-format, 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-format, 0110011/0111011: imm=0, fmt=R, legal.
  - Any other opcode: illegal=1, imm=0, fmt=R.
- out_target is computed for every entry (consumers ignore it when not needed) and wraps at 2^XLEN.
- Skid buffer has two slots: main (drives outputs) and skid.
  - Push: in_valid && in_ready.
  - Pop: out_valid && out_ready.
  - in_ready = !skid_valid.
  - Push with main empty, or main popping this cycle: entry goes to main.
  - Push while main is full and not popping: entry goes to skid.
  - Pop with skid full: skid moves to main.
  - Order is strictly FIFO.
- Simultaneous flush and push: flush wins, and the pushed entry is discarded.
- Nothing beyond the stored entries is lost under backpressure; in_ready never drops mid-cycle.

## Timing
- Latency: one cycle from push to out_valid, when main is empty.
- Throughput: one instruction per cycle while out_ready=1.
- Reset (async assert, synchronous deassert at the top level):
  - out_valid=0, in_ready=1.
  - out_imm, out_target, out_pc = 0.
  - out_fmt=0, out_illegal=0.
  - Both slots invalid.
- Reset mid-transfer drops all entries; no partial entry survives.
- flush=1 at edge N: out_valid=0 and in_ready=1 after edge N, regardless of out_ready. Data registers may hold stale values.
- Data outputs are stable while out_valid && !out_ready.
- The decode path is combinational on in_instr/in_pc ahead of the slot registers. Slots store decoded fields, not raw instructions.

## Structure
- Shared package rv_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32);
  - the imm_fmt_e 3-bit enum.
- One combinational sub-module, imm_extract, parametrised by XLEN: instr in; imm, fmt and illegal out. The stage owns the adder and the skid buffer.

## Test plan
- XLEN=64, push 0xFF813283 (ld x5,-8(x2)), pc=0x100:
  - next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFF8, fmt=I, target=0xF8.
- Push 0xFE000EE3 (beq x0,x0,-4), pc=0x1000:
  - imm=0xFFFFFFFFFFFFFFFC, fmt=B, target=0xFFC, illegal=0.
- Push 0x123450B7 (lui) with XLEN=64 and with XLEN=32:
  - XLEN=64: imm=0x0000000012345000, fmt=U.
  - XLEN=32: imm=0x12345000.
- Push 0x0000007F:
  - out_illegal=1, imm=0, fmt=R.
- out_ready=0, push three back-to-back instructions:
  - first two accepted, in_ready=0 on the third cycle;
  - raise out_ready: outputs appear in order, one per cycle, and the third is then accepted.
- Both slots full, assert flush concurrently with in_valid=1:
  - next cycle out_valid=0, in_ready=1, and no entry ever emerges.
- Deassert reset_n mid-stream: outputs are immediately at reset values.
